// File: rtl/mioc_pkg.sv
// rtl/mioc_pkg.sv - shared types for the mioc line monitors
package mioc_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HIGH   = 2'd0,
        FALL_Q = 2'd1,
        LOW    = 2'd2,
        RISE_Q = 2'd3
    } state_t;

endpackage

// File: rtl/mioc_sync2.sv
// rtl/mioc_sync2.sv - two-flop synchroniser, resets to the idle-high line level
module mioc_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mioc_nor_line_monitor.sv
// rtl/mioc_nor_line_monitor.sv - debounces the NOR output line and reports low pulses as events
module mioc_nor_line_monitor
    import mioc_pkg::*;
#(
    parameter int FILT_CYCLES = 3,
    parameter int WIDTH_W     = 8,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               line_in,
    input  logic               en,
    output logic               level_o,
    output logic               assert_o,
    output logic [CNT_W-1:0]   evt_count,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [WIDTH_W-1:0] evt_width,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam int                 FILT_W   = $clog2(FILT_CYCLES + 1);
    localparam logic [FILT_W-1:0]  FILT_MAX = FILT_W'(FILT_CYCLES);
    localparam logic [FILT_W-1:0]  FILT_ONE = FILT_W'(1);
    localparam logic [WIDTH_W-1:0] ACC_INIT = WIDTH_W'(FILT_CYCLES);
    localparam logic [WIDTH_W-1:0] ACC_ONE  = WIDTH_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    function automatic logic [WIDTH_W-1:0] sat_add(input logic [WIDTH_W-1:0] a,
                                                   input logic [WIDTH_W-1:0] b);
        logic [WIDTH_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH_W] ? {WIDTH_W{1'b1}} : sum[WIDTH_W-1:0];
    endfunction

    logic               s;
    state_t             state, state_nxt;
    logic [FILT_W-1:0]  filt_cnt, filt_nxt;
    logic [WIDTH_W-1:0] acc, acc_nxt;
    logic               enter_low;
    logic               evt_fire;
    logic               evt_pop;

    mioc_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (line_in),
        .q       (s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HIGH;
            filt_cnt <= '0;
            acc      <= '0;
        end else begin
            state    <= state_nxt;
            filt_cnt <= filt_nxt;
            acc      <= acc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        filt_nxt  = filt_cnt;
        acc_nxt   = acc;
        enter_low = 1'b0;
        evt_fire  = 1'b0;
        if (!en) begin
            state_nxt = HIGH;
            filt_nxt  = '0;
            acc_nxt   = '0;
        end else begin
            case (state)
                HIGH: begin
                    if (!s) begin
                        if (FILT_CYCLES == 1) begin
                            state_nxt = LOW;
                            enter_low = 1'b1;
                            acc_nxt   = ACC_INIT;
                            filt_nxt  = '0;
                        end else begin
                            state_nxt = FALL_Q;
                            filt_nxt  = FILT_ONE;
                        end
                    end
                end
                FALL_Q: begin
                    if (!s) begin
                        if (filt_cnt + FILT_ONE == FILT_MAX) begin
                            state_nxt = LOW;
                            enter_low = 1'b1;
                            acc_nxt   = ACC_INIT;
                            filt_nxt  = '0;
                        end else begin
                            filt_nxt = filt_cnt + FILT_ONE;
                        end
                    end else begin
                        state_nxt = HIGH;
                        filt_nxt  = '0;
                    end
                end
                LOW: begin
                    if (!s) begin
                        acc_nxt = sat_add(acc, ACC_ONE);
                    end else if (FILT_CYCLES == 1) begin
                        state_nxt = HIGH;
                        evt_fire  = 1'b1;
                    end else begin
                        state_nxt = RISE_Q;
                        filt_nxt  = FILT_ONE;
                    end
                end
                RISE_Q: begin
                    if (s) begin
                        if (filt_cnt + FILT_ONE == FILT_MAX) begin
                            state_nxt = HIGH;
                            evt_fire  = 1'b1;
                            filt_nxt  = '0;
                        end else begin
                            filt_nxt = filt_cnt + FILT_ONE;
                        end
                    end else begin
                        // a short high glitch inside the pulse still counts towards its width
                        state_nxt = LOW;
                        acc_nxt   = sat_add(acc, WIDTH_W'(filt_cnt) + ACC_ONE);
                        filt_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = HIGH;
                    filt_nxt  = '0;
                end
            endcase
        end
    end

    assign level_o = !((state == LOW) || (state == RISE_Q));
    assign evt_pop = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            assert_o  <= 1'b0;
            evt_count <= '0;
        end else begin
            assert_o <= enter_low;
            if (enter_low) begin
                evt_count <= evt_count + CNT_ONE;
            end
        end
    end

    // 1-deep holding register; a new event never overwrites an unconsumed one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_width <= '0;
            ovf       <= 1'b0;
        end else begin
            if (evt_fire && (!evt_valid || evt_ready)) begin
                evt_valid <= 1'b1;
                evt_width <= acc;
            end else if (evt_pop) begin
                evt_valid <= 1'b0;
            end
            if (evt_fire && evt_valid && !evt_ready) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mioc_nor_line_monitor.sv
// tb/tb_mioc_nor_line_monitor.sv - directed vector bench for mioc_nor_line_monitor
module tb_mioc_nor_line_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       line_in;
    logic       en;
    logic       level_o;
    logic       assert_o;
    logic [7:0] evt_count;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_width;
    logic       ovf;
    logic       ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int assert_seen = 0;
    int exp_count = 0;

    typedef struct {
        int low1;
        int gap;
        int low2;
        int exp_evt;
        int exp_width;
        int exp_asserts;
    } vec_t;

    vec_t vecs[9];

    mioc_nor_line_monitor #(
        .FILT_CYCLES (3),
        .WIDTH_W     (8),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .line_in   (line_in),
        .en        (en),
        .level_o   (level_o),
        .assert_o  (assert_o),
        .evt_count (evt_count),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_width (evt_width),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (assert_o === 1'b1) assert_seen++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        line_in = v;
        repeat (n) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    initial begin
        int base;
        reset_n   = 1'b0;
        line_in   = 1'b1;
        en        = 1'b1;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        vecs[0] = '{10,  0, 0, 1, 10,  1};
        vecs[1] = '{2,   0, 0, 0, 0,   0};
        vecs[2] = '{1,   0, 0, 0, 0,   0};
        vecs[3] = '{3,   0, 0, 1, 3,   1};
        vecs[4] = '{20,  2, 10, 1, 32, 1};
        vecs[5] = '{5,   1, 4, 1, 10,  1};
        vecs[6] = '{6,   2, 1, 1, 9,   1};
        vecs[7] = '{300, 0, 0, 1, 255, 1};
        vecs[8] = '{2,   1, 2, 0, 0,   0};

        repeat (2) tick();
        check("rst_level", int'(level_o), 1);
        check("rst_assert", int'(assert_o), 0);
        check("rst_count", int'(evt_count), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_width", int'(evt_width), 0);
        check("rst_ovf", int'(ovf), 0);
        reset_n = 1'b1;
        drive(1'b1, 4);

        // table: each pattern is followed by enough idle time to complete, event held until popped
        for (int i = 0; i < 9; i++) begin
            base = assert_seen;
            drive(1'b0, vecs[i].low1);
            if (vecs[i].gap > 0) begin
                drive(1'b1, vecs[i].gap);
                drive(1'b0, vecs[i].low2);
            end
            drive(1'b1, 8);
            exp_count = (exp_count + vecs[i].exp_asserts) % 256;
            check($sformatf("vec%0d_valid", i), int'(evt_valid), vecs[i].exp_evt);
            if (vecs[i].exp_evt != 0)
                check($sformatf("vec%0d_width", i), int'(evt_width), vecs[i].exp_width);
            check($sformatf("vec%0d_asserts", i), assert_seen - base, vecs[i].exp_asserts);
            check($sformatf("vec%0d_count", i), int'(evt_count), exp_count);
            check($sformatf("vec%0d_level", i), int'(level_o), 1);
            check($sformatf("vec%0d_ovf", i), int'(ovf), 0);
            pop();
            check($sformatf("vec%0d_popped", i), int'(evt_valid), 0);
        end

        // latency: first low sample at edge k, assert_o after edge k+4 for one cycle
        line_in = 1'b0;
        tick();
        repeat (3) tick();
        check("lat_pre_assert", int'(assert_o), 0);
        check("lat_pre_level", int'(level_o), 1);
        tick();
        check("lat_assert", int'(assert_o), 1);
        check("lat_level", int'(level_o), 0);
        tick();
        check("lat_assert_one_cycle", int'(assert_o), 0);
        drive(1'b1, 8);
        exp_count = (exp_count + 1) % 256;
        check("lat_width", int'(evt_width), 6);
        check("lat_count", int'(evt_count), exp_count);
        pop();

        // overflow with consumer stalled
        drive(1'b0, 5);
        drive(1'b1, 8);
        drive(1'b0, 5);
        drive(1'b1, 8);
        exp_count = (exp_count + 2) % 256;
        check("ovf_valid", int'(evt_valid), 1);
        check("ovf_width_held", int'(evt_width), 5);
        check("ovf_set", int'(ovf), 1);
        check("ovf_count", int'(evt_count), exp_count);
        drive(1'b0, 5);
        drive(1'b1, 4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr_collide", int'(ovf), 1);
        check("ovf_width_still", int'(evt_width), 5);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(ovf), 0);

        // reset while in LOW with an event pending
        base = assert_seen;
        drive(1'b0, 8);
        check("mid_level_low", int'(level_o), 0);
        reset_n = 1'b0;
        #1;
        check("midrst_level", int'(level_o), 1);
        check("midrst_assert", int'(assert_o), 0);
        check("midrst_count", int'(evt_count), 0);
        check("midrst_valid", int'(evt_valid), 0);
        check("midrst_width", int'(evt_width), 0);
        check("midrst_ovf", int'(ovf), 0);
        line_in = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        drive(1'b1, 10);
        exp_count = 0;
        check("midrst_no_evt", int'(evt_valid), 0);
        check("midrst_count_after", int'(evt_count), 0);
        check("midrst_asserts", assert_seen - base, 1);

        // en dropped during a pulse
        drive(1'b0, 6);
        exp_count = 1;
        en = 1'b0;
        tick();
        check("en_level", int'(level_o), 1);
        drive(1'b0, 6);
        drive(1'b1, 10);
        check("en_no_evt", int'(evt_valid), 0);
        check("en_count_kept", int'(evt_count), exp_count);
        en = 1'b1;
        drive(1'b1, 4);

        // counter wrap from a fresh reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        evt_ready = 1'b1;
        for (int p = 0; p < 256; p++) begin
            drive(1'b0, 4);
            drive(1'b1, 6);
            if (p == 254) check("wrap_255", int'(evt_count), 255);
        end
        check("wrap_0", int'(evt_count), 0);
        check("wrap_width", int'(evt_width), 4);
        check("wrap_no_ovf", int'(ovf), 0);
        evt_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
